// File: rtl/dsp_writeback_if.sv
// Bus bundle between the memory stage, decode, and the write-back stage.
interface dsp_writeback_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  stall;
    logic                  flush;
    logic                  valid_in;
    logic [DATA_W-1:0]     mem_out_in;
    logic                  wb_en_in;
    logic [REG_ADDR_W-1:0] wb_dest_in;
    logic [REG_ADDR_W-1:0] rd_addr_a;
    logic [REG_ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0]     rd_data_a;
    logic [DATA_W-1:0]     rd_data_b;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]     wb_data;
    logic [CNT_W-1:0]      retire_count;

    // Write-back stage side.
    modport slave (
        input  stall, flush, valid_in, mem_out_in, wb_en_in, wb_dest_in,
        input  rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_valid, wb_dest, wb_data, retire_count
    );

    // Upstream / decode side.
    modport master (
        output stall, flush, valid_in, mem_out_in, wb_en_in, wb_dest_in,
        output rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_valid, wb_dest, wb_data, retire_count
    );
endinterface

// File: rtl/dsp_writeback.sv
// Write-back stage: MEM/WB register, 16-entry register file with bypassed
// read ports, and a saturating retired-instruction counter.
module dsp_writeback #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    dsp_writeback_if.slave bus
);
    localparam int NREGS = 1 << REG_ADDR_W;

    logic                  wb_valid;
    logic                  wb_en_q;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]     wb_data;
    logic [CNT_W-1:0]      retire_count;
    logic [DATA_W-1:0]     regs [NREGS];
    logic                  commit;
    logic                  capture;
    logic [DATA_W-1:0]     rd_data_a;
    logic [DATA_W-1:0]     rd_data_b;

    // The held instruction commits regardless of this cycle's stall/flush.
    assign commit  = wb_valid & wb_en_q & (wb_dest != '0);
    assign capture = bus.valid_in & ~bus.stall & ~bus.flush;

    // MEM/WB register: flush empties the stage, stall holds it, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_en_q  <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
        end else if (bus.flush) begin
            wb_valid <= 1'b0;
            wb_en_q  <= 1'b0;
        end else if (!bus.stall) begin
            wb_valid <= bus.valid_in;
            wb_en_q  <= bus.wb_en_in;
            wb_dest  <= bus.wb_dest_in;
            wb_data  <= bus.mem_out_in;
        end
    end

    // Register file write from the MEM/WB register; R0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // Retire counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (capture && (retire_count != {CNT_W{1'b1}})) begin
            retire_count <= retire_count + 1'b1;
        end
    end

    // Read ports: R0 is zero, then bypass from MEM/WB, then the file.
    always_comb begin
        rd_data_a = regs[bus.rd_addr_a];
        if (bus.rd_addr_a == '0) begin
            rd_data_a = '0;
        end else if (wb_valid && wb_en_q && (wb_dest == bus.rd_addr_a)) begin
            rd_data_a = wb_data;
        end

        rd_data_b = regs[bus.rd_addr_b];
        if (bus.rd_addr_b == '0) begin
            rd_data_b = '0;
        end else if (wb_valid && wb_en_q && (wb_dest == bus.rd_addr_b)) begin
            rd_data_b = wb_data;
        end
    end

    assign bus.rd_data_a    = rd_data_a;
    assign bus.rd_data_b    = rd_data_b;
    assign bus.wb_valid     = wb_valid;
    assign bus.wb_dest      = wb_dest;
    assign bus.wb_data      = wb_data;
    assign bus.retire_count = retire_count;
endmodule

// File: tb/tb_dsp_writeback.sv
// Directed bench for dsp_writeback with hand-computed expectations.
module tb_dsp_writeback;
    logic clk;
    logic rst_n;
    int   vec;
    int   errs;

    dsp_writeback_if #(.DATA_W(16), .REG_ADDR_W(4), .CNT_W(16)) bus ();

    dsp_writeback #(.DATA_W(16), .REG_ADDR_W(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required summary before limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.valid_in   = 1'b0;
        bus.wb_en_in   = 1'b0;
        bus.wb_dest_in = 4'd0;
        bus.mem_out_in = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.valid_in   = 1'b1;
        bus.wb_en_in   = 1'b1;
        bus.wb_dest_in = 4'd6;
        bus.mem_out_in = 16'hDEAD;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.rd_addr_a  = 4'd6;
        bus.rd_addr_b  = 4'd6;
        repeat (4) @(posedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vec++; if (bus.wb_valid !== 1'b0) begin errs++; $display("FAIL reset_wb_valid got %0h want 0", bus.wb_valid); end
        vec++; if (bus.retire_count !== 16'h0000) begin errs++; $display("FAIL reset_retire_count got %0h want 0", bus.retire_count); end
        vec++; if (bus.wb_data !== 16'h0000) begin errs++; $display("FAIL reset_wb_data got %0h want 0", bus.wb_data); end
        vec++; if (bus.wb_dest !== 4'd0) begin errs++; $display("FAIL reset_wb_dest got %0h want 0", bus.wb_dest); end
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr_a = 4'(i);
            bus.rd_addr_b = 4'(15 - i);
            #1;
            vec++; if (bus.rd_data_a !== 16'h0000) begin errs++; $display("FAIL reset_rd_a[%0d] got %0h want 0", i, bus.rd_data_a); end
            vec++; if (bus.rd_data_b !== 16'h0000) begin errs++; $display("FAIL reset_rd_b[%0d] got %0h want 0", 15 - i, bus.rd_data_b); end
        end
    endtask

    task automatic test_basic();
        bus.valid_in   = 1'b1;
        bus.wb_en_in   = 1'b1;
        bus.wb_dest_in = 4'd3;
        bus.mem_out_in = 16'hBEEF;
        bus.rd_addr_a  = 4'd3;
        tick();
        idle_inputs();
        #1;
        vec++; if (bus.wb_valid !== 1'b1) begin errs++; $display("FAIL basic_wb_valid got %0h want 1", bus.wb_valid); end
        vec++; if (bus.wb_data !== 16'hBEEF) begin errs++; $display("FAIL basic_wb_data got %0h want beef", bus.wb_data); end
        vec++; if (bus.rd_data_a !== 16'hBEEF) begin errs++; $display("FAIL basic_bypass got %0h want beef", bus.rd_data_a); end
        vec++; if (bus.retire_count !== 16'd1) begin errs++; $display("FAIL basic_count got %0h want 1", bus.retire_count); end
        tick();
        vec++; if (bus.wb_valid !== 1'b0) begin errs++; $display("FAIL basic_wb_valid_idle got %0h want 0", bus.wb_valid); end
        vec++; if (bus.rd_data_a !== 16'hBEEF) begin errs++; $display("FAIL basic_file_read got %0h want beef", bus.rd_data_a); end
    endtask

    task automatic test_r0_gating();
        logic [15:0] c0;
        c0 = bus.retire_count;
        bus.valid_in   = 1'b1;
        bus.wb_en_in   = 1'b1;
        bus.wb_dest_in = 4'd0;
        bus.mem_out_in = 16'h1234;
        bus.rd_addr_a  = 4'd0;
        bus.rd_addr_b  = 4'd5;
        tick();
        bus.wb_en_in   = 1'b0;
        bus.wb_dest_in = 4'd5;
        bus.mem_out_in = 16'hAAAA;
        #1;
        vec++; if (bus.rd_data_a !== 16'h0000) begin errs++; $display("FAIL r0_bypass got %0h want 0", bus.rd_data_a); end
        tick();
        idle_inputs();
        #1;
        vec++; if (bus.rd_data_b !== 16'h0000) begin errs++; $display("FAIL r5_no_bypass got %0h want 0", bus.rd_data_b); end
        tick();
        vec++; if (bus.rd_data_b !== 16'h0000) begin errs++; $display("FAIL r5_file got %0h want 0", bus.rd_data_b); end
        vec++; if (bus.rd_data_a !== 16'h0000) begin errs++; $display("FAIL r0_file got %0h want 0", bus.rd_data_a); end
        vec++; if (bus.retire_count !== c0 + 16'd2) begin errs++; $display("FAIL r0_count got %0h want %0h", bus.retire_count, c0 + 16'd2); end
    endtask

    task automatic test_stall_flush();
        logic [15:0] c0;
        c0 = bus.retire_count;
        bus.valid_in   = 1'b1;
        bus.wb_en_in   = 1'b1;
        bus.wb_dest_in = 4'd7;
        bus.mem_out_in = 16'h00FF;
        bus.rd_addr_a  = 4'd7;
        tick();
        bus.stall      = 1'b1;
        bus.mem_out_in = 16'h5555;
        bus.wb_dest_in = 4'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++; if (bus.wb_data !== 16'h00FF) begin errs++; $display("FAIL stall_wb_data[%0d] got %0h want 00ff", i, bus.wb_data); end
            vec++; if (bus.wb_dest !== 4'd7) begin errs++; $display("FAIL stall_wb_dest[%0d] got %0h want 7", i, bus.wb_dest); end
            vec++; if (bus.retire_count !== c0 + 16'd1) begin errs++; $display("FAIL stall_count[%0d] got %0h want %0h", i, bus.retire_count, c0 + 16'd1); end
        end
        bus.flush      = 1'b1;
        bus.wb_dest_in = 4'd7;
        bus.mem_out_in = 16'h1111;
        tick();
        vec++; if (bus.wb_valid !== 1'b0) begin errs++; $display("FAIL flush_wb_valid got %0h want 0", bus.wb_valid); end
        vec++; if (bus.wb_data !== 16'h00FF) begin errs++; $display("FAIL flush_wb_data_hold got %0h want 00ff", bus.wb_data); end
        vec++; if (bus.retire_count !== c0 + 16'd1) begin errs++; $display("FAIL flush_count got %0h want %0h", bus.retire_count, c0 + 16'd1); end
        vec++; if (bus.rd_data_a !== 16'h00FF) begin errs++; $display("FAIL stall_r7_file got %0h want 00ff", bus.rd_data_a); end
        idle_inputs();
        tick();
        tick();
        vec++; if (bus.rd_data_a !== 16'h00FF) begin errs++; $display("FAIL flush_no_write_r7 got %0h want 00ff", bus.rd_data_a); end
    endtask

    task automatic test_back_to_back();
        bus.valid_in   = 1'b1;
        bus.wb_en_in   = 1'b1;
        bus.wb_dest_in = 4'd2;
        bus.mem_out_in = 16'h0001;
        bus.rd_addr_b  = 4'd2;
        tick();
        bus.mem_out_in = 16'h0002;
        #1;
        vec++; if (bus.rd_data_b !== 16'h0001) begin errs++; $display("FAIL raw_first got %0h want 0001", bus.rd_data_b); end
        tick();
        idle_inputs();
        #1;
        vec++; if (bus.rd_data_b !== 16'h0002) begin errs++; $display("FAIL raw_second got %0h want 0002", bus.rd_data_b); end
        tick();
        vec++; if (bus.rd_data_b !== 16'h0002) begin errs++; $display("FAIL raw_file got %0h want 0002", bus.rd_data_b); end
    endtask

    task automatic test_async_reset();
        bus.valid_in   = 1'b1;
        bus.wb_en_in   = 1'b1;
        bus.wb_dest_in = 4'd9;
        bus.mem_out_in = 16'h9999;
        bus.rd_addr_a  = 4'd9;
        tick();
        idle_inputs();
        #1;
        vec++; if (bus.rd_data_a !== 16'h9999) begin errs++; $display("FAIL pend_r9_bypass got %0h want 9999", bus.rd_data_a); end
        rst_n = 1'b0;
        #1;
        vec++; if (bus.wb_valid !== 1'b0) begin errs++; $display("FAIL arst_wb_valid got %0h want 0", bus.wb_valid); end
        vec++; if (bus.rd_data_a !== 16'h0000) begin errs++; $display("FAIL arst_r9_during got %0h want 0", bus.rd_data_a); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vec++; if (bus.rd_data_a !== 16'h0000) begin errs++; $display("FAIL arst_r9_after got %0h want 0", bus.rd_data_a); end
        vec++; if (bus.retire_count !== 16'h0000) begin errs++; $display("FAIL arst_count got %0h want 0", bus.retire_count); end
    endtask

    task automatic test_saturation();
        bus.valid_in = 1'b1;
        bus.wb_en_in = 1'b0;
        repeat (16'hFFFE) tick();
        vec++; if (bus.retire_count !== 16'hFFFE) begin errs++; $display("FAIL sat_preload got %0h want fffe", bus.retire_count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++; if (bus.retire_count !== 16'hFFFF) begin errs++; $display("FAIL sat_hold[%0d] got %0h want ffff", i, bus.retire_count); end
        end
        idle_inputs();
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        rst_n = 1'b0;
        idle_inputs();
        bus.rd_addr_a = 4'd0;
        bus.rd_addr_b = 4'd0;
        test_reset();
        test_basic();
        test_r0_gating();
        test_stall_flush();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
